// File: rtl/regfile_sb_pkg.sv
// Shared types and constants for the scoreboarded register file.
package regfile_sb_pkg;
  typedef logic [4:0] regaddr_t;
  localparam int NUM_REGS = 32;
  localparam logic [1:0] MAX_PENDING = 2'd3;
endpackage

// File: rtl/regfile_sb_pend_ctr.sv
// Per-register pending-write counter: saturating 2-bit up/down count.
module pend_ctr
  import regfile_sb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] count,
  output logic       nonzero
);

  logic [1:0] count_r;
  logic [1:0] count_nxt_s;

  // Next count: simultaneous inc and dec cancel; saturate at both ends.
  always_comb begin
    count_nxt_s = count_r;
    if (inc && !dec) begin
      if (count_r != MAX_PENDING) count_nxt_s = count_r + 2'd1;
      else                        count_nxt_s = count_r;
    end else if (dec && !inc) begin
      if (count_r != 2'd0) count_nxt_s = count_r - 2'd1;
      else                 count_nxt_s = count_r;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_r <= 2'd0;
    else        count_r <= count_nxt_s;
  end

  assign count   = count_r;
  assign nonzero = (count_r != 2'd0);

endmodule

// File: rtl/regfile_sb.sv
// 32 x width register file with write-through bypass and a pending-write
// scoreboard (one saturating counter per register x1..x31).
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  regaddr_t         dest,
  input  logic [width-1:0] in,
  input  regaddr_t         src_a,
  input  regaddr_t         src_b,
  output logic [width-1:0] reg_a,
  output logic [width-1:0] reg_b,
  input  logic             reserve,
  input  regaddr_t         reserve_rd,
  output logic             reserve_ok,
  output logic             busy_a,
  output logic             busy_b
);

  logic [width-1:0]    regs_r [NUM_REGS];
  logic [1:0]          count_s [NUM_REGS];
  logic [NUM_REGS-1:0] nonzero_s;
  logic                bypass_a_s;
  logic                bypass_b_s;
  logic                same_reg_s;

  assign count_s[0]   = 2'd0;
  assign nonzero_s[0] = 1'b0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_ctr
    pend_ctr u_ctr (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc     (reserve && (reserve_rd == regaddr_t'(i))),
      .dec     (load && (dest == regaddr_t'(i))),
      .count   (count_s[i]),
      .nonzero (nonzero_s[i])
    );
  end

  // Register storage; x0 is never written so it stays at its reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) regs_r[r] <= '0;
    end else if (load && (dest != 5'd0)) begin
      regs_r[dest] <= in;
    end
  end

  // Bypass is gated by rst_n so outputs read zero throughout reset.
  always_comb begin
    bypass_a_s = rst_n && load && (dest == src_a) && (src_a != 5'd0);
    bypass_b_s = rst_n && load && (dest == src_b) && (src_b != 5'd0);
    same_reg_s = load && (dest == reserve_rd);

    if (src_a == 5'd0)   reg_a = '0;
    else if (bypass_a_s) reg_a = in;
    else                 reg_a = regs_r[src_a];

    if (src_b == 5'd0)   reg_b = '0;
    else if (bypass_b_s) reg_b = in;
    else                 reg_b = regs_r[src_b];

    // A final pending write retiring this cycle is already visible via bypass.
    busy_a = nonzero_s[src_a] && !(bypass_a_s && (count_s[src_a] == 2'd1));
    busy_b = nonzero_s[src_b] && !(bypass_b_s && (count_s[src_b] == 2'd1));

    reserve_ok = !(reserve && (reserve_rd != 5'd0) &&
                   (count_s[reserve_rd] == MAX_PENDING) && !same_reg_s);
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb.
module tb_regfile_sb;
  import regfile_sb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  regaddr_t    dest;
  logic [31:0] in;
  regaddr_t    src_a;
  regaddr_t    src_b;
  logic [31:0] reg_a;
  logic [31:0] reg_b;
  logic        reserve;
  regaddr_t    reserve_rd;
  logic        reserve_ok;
  logic        busy_a;
  logic        busy_b;

  int pass_cnt  = 0;
  int total_cnt = 0;

  regfile_sb #(.width(32)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .dest(dest), .in(in),
    .src_a(src_a), .src_b(src_b), .reg_a(reg_a), .reg_b(reg_b),
    .reserve(reserve), .reserve_rd(reserve_rd), .reserve_ok(reserve_ok),
    .busy_a(busy_a), .busy_b(busy_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    load = 1'b0; dest = 5'd0; in = 32'd0;
    reserve = 1'b0; reserve_rd = 5'd0;
  endtask

  initial begin
    // Reset with live-looking inputs: bypass must not leak through.
    rst_n = 1'b0; load = 1'b1; dest = 5'd5; in = 32'hAAAA_5555;
    src_a = 5'd5; src_b = 5'd5; reserve = 1'b1; reserve_rd = 5'd3;
    @(negedge clk); #1;
    check("rst_reg_a", reg_a, 32'd0);
    check("rst_reg_b", reg_b, 32'd0);
    check("rst_busy_a", {31'd0, busy_a}, 32'd0);
    check("rst_busy_b", {31'd0, busy_b}, 32'd0);
    check("rst_resv_ok", {31'd0, reserve_ok}, 32'd1);

    rst_n = 1'b1; idle(); src_a = 5'd0; src_b = 5'd0;
    cyc();

    // Write x5, read back next cycle.
    load = 1'b1; dest = 5'd5; in = 32'hDEAD_BEEF;
    cyc();
    idle(); src_a = 5'd5; src_b = 5'd0; #1;
    check("wr_x5_a", reg_a, 32'hDEAD_BEEF);
    check("x0_b", reg_b, 32'd0);

    // Write-through bypass for x7.
    load = 1'b1; dest = 5'd7; in = 32'h0000_1234; src_a = 5'd7; src_b = 5'd5; #1;
    check("bypass_x7", reg_a, 32'h0000_1234);
    check("x5_b_during", reg_b, 32'hDEAD_BEEF);
    cyc();
    idle(); #1;
    check("stored_x7", reg_a, 32'h0000_1234);

    // Writes to x0 are discarded, including bypass.
    load = 1'b1; dest = 5'd0; in = 32'hFFFF_FFFF; src_a = 5'd0; #1;
    check("x0_bypass", reg_a, 32'd0);
    cyc();
    idle(); #1;
    check("x0_after", reg_a, 32'd0);

    // Reserving x0 is always accepted.
    reserve = 1'b1; reserve_rd = 5'd0; #1;
    check("resv_x0", {31'd0, reserve_ok}, 32'd1);
    cyc();

    // Four reserves of x3: 1,1,1,0.
    src_a = 5'd3;
    for (int k = 0; k < 4; k++) begin
      reserve = 1'b1; reserve_rd = 5'd3; #1;
      check($sformatf("resv_x3_%0d", k), {31'd0, reserve_ok}, (k < 3) ? 32'd1 : 32'd0);
      check($sformatf("busy_x3_pre%0d", k), {31'd0, busy_a}, (k > 0) ? 32'd1 : 32'd0);
      cyc();
    end
    idle(); #1;
    check("busy_x3_held", {31'd0, busy_a}, 32'd1);
    // Three loads drain x3; busy drops during the third.
    for (int k = 0; k < 3; k++) begin
      load = 1'b1; dest = 5'd3; in = 32'h3000_0000 + k; #1;
      check($sformatf("busy_x3_ld%0d", k), {31'd0, busy_a}, (k < 2) ? 32'd1 : 32'd0);
      cyc();
    end
    idle(); #1;
    check("busy_x3_done", {31'd0, busy_a}, 32'd0);
    check("data_x3", reg_a, 32'h3000_0002);

    // x9: fill to 3, then same-cycle reserve+load keeps it at 3.
    src_a = 5'd9;
    for (int k = 0; k < 3; k++) begin
      reserve = 1'b1; reserve_rd = 5'd9; cyc();
    end
    reserve = 1'b1; reserve_rd = 5'd9; load = 1'b1; dest = 5'd9; in = 32'h0000_0099; #1;
    check("resv_ld_x9_ok", {31'd0, reserve_ok}, 32'd1);
    cyc();
    idle(); reserve = 1'b1; reserve_rd = 5'd9; #1;
    check("x9_still_full", {31'd0, reserve_ok}, 32'd0);
    check("x9_data", reg_a, 32'h0000_0099);
    idle();
    for (int k = 0; k < 3; k++) begin
      load = 1'b1; dest = 5'd9; in = 32'h0000_0090 + k; #1;
      check($sformatf("busy_x9_ld%0d", k), {31'd0, busy_a}, (k < 2) ? 32'd1 : 32'd0);
      cyc();
    end
    // Untracked write to x9 with count 0.
    load = 1'b1; dest = 5'd9; in = 32'h0000_CAFE; #1;
    check("busy_x9_untracked", {31'd0, busy_a}, 32'd0);
    cyc();
    idle(); #1;
    check("x9_untracked_data", reg_a, 32'h0000_CAFE);
    check("x9_no_underflow", {31'd0, busy_a}, 32'd0);
    // One reserve after the untracked write must give count 1, not 3.
    reserve = 1'b1; reserve_rd = 5'd9; cyc();
    idle(); load = 1'b1; dest = 5'd9; in = 32'h0000_0009; #1;
    check("x9_count_one", {31'd0, busy_a}, 32'd0);
    cyc();
    idle();

    // Reserve and load on different registers in one cycle.
    reserve = 1'b1; reserve_rd = 5'd10; load = 1'b1; dest = 5'd11; in = 32'h0000_0B0B;
    cyc();
    idle(); src_a = 5'd11; src_b = 5'd10; #1;
    check("diff_x11_data", reg_a, 32'h0000_0B0B);
    check("diff_x11_busy", {31'd0, busy_a}, 32'd0);
    check("diff_x10_busy", {31'd0, busy_b}, 32'd1);

    // Reset mid-cycle with outstanding reservations on x4.
    load = 1'b1; dest = 5'd4; in = 32'h0000_0055; cyc();
    idle(); reserve = 1'b1; reserve_rd = 5'd4; cyc(); cyc();
    idle(); src_a = 5'd4; src_b = 5'd10; #1;
    check("x4_busy_pre", {31'd0, busy_a}, 32'd1);
    check("x4_data_pre", reg_a, 32'h0000_0055);
    #1 rst_n = 1'b0; #1;
    check("async_busy_a", {31'd0, busy_a}, 32'd0);
    check("async_busy_b", {31'd0, busy_b}, 32'd0);
    check("async_reg_a", reg_a, 32'd0);
    check("async_resv_ok", {31'd0, reserve_ok}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    load = 1'b1; dest = 5'd4; in = 32'h0000_0077; #1;
    check("post_rst_busy", {31'd0, busy_a}, 32'd0);
    check("post_rst_bypass", reg_a, 32'h0000_0077);
    cyc();
    idle(); #1;
    check("post_rst_data", reg_a, 32'h0000_0077);
    check("post_rst_busy2", {31'd0, busy_a}, 32'd0);
    check("post_rst_x10", {31'd0, busy_b}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
